// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind the MEM stage.
// A level-held load/store request is accepted from IDLE, the pipeline is
// stalled for LATENCY cycles, and the access result is presented in DONE
// for exactly one cycle.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   mem_read          load request, held until mem_stall drops
//   mem_write         store request, held until mem_stall drops (wins over mem_read)
//   adr[31:0]         byte address, word index = adr[log2(DEPTH)+1:2]
//   write_data[31:0]  store data
//   read_data[31:0]   registered load result, held until the next load completes
//   mem_stall         freeze request for the IF/ID/EX/MEM pipeline registers
//   rd_valid          one-cycle pulse in DONE for loads
//   err               one-cycle pulse in DONE for out-of-range requests
//   out1, out2        continuous debug view of words 0 and 1
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] adr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        mem_stall,
   output logic        rd_valid,
   output logic        err,
   output logic [31:0] out1,
   output logic [31:0] out2
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t state, next_state;

   logic [31:0]   mem [DEPTH];
   logic [CW-1:0] cnt;

   logic          req;
   logic          in_oor;

   logic          lat_wr;
   logic          lat_rd;
   logic          lat_oor;
   logic [AW-1:0] lat_idx;
   logic [31:0]   lat_wd;

   logic          access;
   logic          use_in;
   logic          acc_wr;
   logic          acc_rd;
   logic          acc_oor;
   logic [AW-1:0] acc_idx;
   logic [31:0]   acc_wd;

   logic          done_rd;
   logic          done_err;

   assign req = mem_read | mem_write;
   // adr >= DEPTH*4 is the same test as adr[31:2] >= DEPTH; byte offset cannot matter.
   assign in_oor = (adr >= (32'(DEPTH) << 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      mem_stall  = 1'b0;
      access     = 1'b0;
      use_in     = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               mem_stall = 1'b1;
               if (LATENCY == 1) begin
                  // Single-cycle latency: access straight from the inputs on the accept edge.
                  access     = 1'b1;
                  use_in     = 1'b1;
                  next_state = DONE;
               end else begin
                  next_state = BUSY;
               end
            end
         end
         BUSY: begin
            mem_stall = 1'b1;
            if (cnt == '0) begin
               access     = 1'b1;
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      acc_wr  = use_in ? mem_write : lat_wr;
      acc_rd  = use_in ? (mem_read & ~mem_write) : lat_rd;
      acc_oor = use_in ? in_oor : lat_oor;
      acc_idx = use_in ? adr[AW+1:2] : lat_idx;
      acc_wd  = use_in ? write_data : lat_wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         lat_wr    <= 1'b0;
         lat_rd    <= 1'b0;
         lat_oor   <= 1'b0;
         lat_idx   <= '0;
         lat_wd    <= '0;
         read_data <= '0;
         done_rd   <= 1'b0;
         done_err  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (state == IDLE && req) begin
            lat_wr  <= mem_write;
            lat_rd  <= mem_read & ~mem_write;
            lat_oor <= in_oor;
            lat_idx <= adr[AW+1:2];
            lat_wd  <= write_data;
            cnt     <= CNT_LOAD;
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (access) begin
            done_rd  <= acc_rd;
            done_err <= acc_oor;
            if (acc_wr && !acc_oor) begin
               mem[acc_idx] <= acc_wd;
            end
            if (acc_rd) begin
               read_data <= acc_oor ? '0 : mem[acc_idx];
            end
         end
      end
   end

   assign rd_valid = (state == DONE) & done_rd;
   assign err      = (state == DONE) & done_err;
   assign out1     = mem[0];
   assign out2     = mem[1];

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Instance u_dut uses the default LATENCY=3, DEPTH=256; u_dut1 uses LATENCY=1.
// Inputs change #1 after a rising edge; outputs are sampled on the falling edge.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] adr, write_data;
   logic [31:0] read_data, out1, out2;
   logic        mem_stall, rd_valid, err;

   logic        rd1, wr1;
   logic [31:0] adr1, wd1;
   logic [31:0] read_data1, out1_1, out2_1;
   logic        stall1, rd_valid1, err1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int stall_cnt;
   int t_start;

   dmem_responder #(.DEPTH(256), .LATENCY(3)) u_dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .adr(adr), .write_data(write_data),
      .read_data(read_data), .mem_stall(mem_stall),
      .rd_valid(rd_valid), .err(err),
      .out1(out1), .out2(out2)
   );

   dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .mem_read(rd1), .mem_write(wr1),
      .adr(adr1), .write_data(wd1),
      .read_data(read_data1), .mem_stall(stall1),
      .rd_valid(rd_valid1), .err(err1),
      .out1(out1_1), .out2(out2_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents a request and follows it until mem_stall drops (bounded); ends
   // at the falling edge of the DONE cycle with the request still applied.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      tick();
      mem_read   = rd;
      mem_write  = wr;
      adr        = a;
      write_data = wd;
      stall_cnt  = 0;
      sample();
      while (mem_stall === 1'b1 && stall_cnt < 20) begin
         stall_cnt++;
         tick();
         sample();
      end
   endtask

   task automatic release_req();
      tick();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      sample();
   endtask

   initial begin
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; adr = '0; write_data = '0;
      rd1 = 1'b0; wr1 = 1'b0; adr1 = '0; wd1 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      sample();
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_read_data", read_data, 32'h0);
      check("rst_out1", out1, 32'h0);
      check("rst_out2", out2, 32'h0);
      tick();
      rst = 1'b0;

      // Load from a fresh word: 3 stall cycles then DONE with zero data
      access(1'b1, 1'b0, 32'h8, 32'h0);
      check("ld0_stall_cycles", 32'(stall_cnt), 32'd3);
      check("ld0_rd_valid", 32'(rd_valid), 32'd1);
      check("ld0_read_data", read_data, 32'h0);
      check("ld0_err", 32'(err), 32'd0);
      release_req();
      check("ld0_pulse_end", 32'(rd_valid), 32'd0);
      check("ld0_idle_stall", 32'(mem_stall), 32'd0);

      // Store to word 1, then load it back
      access(1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
      check("st1_stall_cycles", 32'(stall_cnt), 32'd3);
      check("st1_rd_valid", 32'(rd_valid), 32'd0);
      check("st1_out2", out2, 32'hDEADBEEF);
      check("st1_out1", out1, 32'h0);
      release_req();
      access(1'b1, 1'b0, 32'h4, 32'h0);
      check("ld1_stall_cycles", 32'(stall_cnt), 32'd3);
      check("ld1_rd_valid", 32'(rd_valid), 32'd1);
      check("ld1_read_data", read_data, 32'hDEADBEEF);
      release_req();

      // Back-to-back store/load on word 2: 8 cycles cover both accesses
      tick();
      mem_write = 1'b1; adr = 32'h8; write_data = 32'h0000_0011;
      t_start = cyc;
      stall_cnt = 0;
      sample();
      while (mem_stall === 1'b1 && stall_cnt < 20) begin
         stall_cnt++;
         tick();
         sample();
      end
      check("b2b_st_stall_cycles", 32'(stall_cnt), 32'd3);
      check("b2b_st_rd_valid", 32'(rd_valid), 32'd0);
      access(1'b1, 1'b0, 32'h8, 32'h0);
      check("b2b_ld_stall_cycles", 32'(stall_cnt), 32'd3);
      check("b2b_total_cycles", 32'(cyc - t_start + 1), 32'd8);
      check("b2b_ld_rd_valid", 32'(rd_valid), 32'd1);
      check("b2b_ld_read_data", read_data, 32'h0000_0011);
      release_req();

      // Out-of-range load and store (index bits of 0x400 alias word 0)
      access(1'b1, 1'b0, 32'h400, 32'h0);
      check("oor_ld_err", 32'(err), 32'd1);
      check("oor_ld_rd_valid", 32'(rd_valid), 32'd1);
      check("oor_ld_read_data", read_data, 32'h0);
      release_req();
      check("oor_err_pulse_end", 32'(err), 32'd0);
      access(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF);
      check("oor_st_err", 32'(err), 32'd1);
      check("oor_st_rd_valid", 32'(rd_valid), 32'd0);
      release_req();
      check("oor_st_out1", out1, 32'h0);
      check("oor_st_out2", out2, 32'hDEADBEEF);
      access(1'b1, 1'b0, 32'h0, 32'h0);
      check("oor_st_word0", read_data, 32'h0);
      release_req();

      // Reset while BUSY with a pending store to word 0
      tick();
      mem_write = 1'b1; adr = 32'h0; write_data = 32'h12345678;
      sample();
      check("rb_accept_stall", 32'(mem_stall), 32'd1);
      tick();
      sample();
      check("rb_busy_stall", 32'(mem_stall), 32'd1);
      #1;
      rst = 1'b1;
      mem_write = 1'b0;
      #1;
      check("rb_stall", 32'(mem_stall), 32'd0);
      check("rb_out1", out1, 32'h0);
      check("rb_out2", out2, 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample();
         check("rb_no_rd_valid", 32'(rd_valid), 32'd0);
         check("rb_no_err", 32'(err), 32'd0);
         check("rb_no_store", out1, 32'h0);
         tick();
      end

      // Simultaneous read/write behaves as a store; read_data retained
      access(1'b0, 1'b1, 32'hC, 32'h0000_005A);
      release_req();
      access(1'b1, 1'b0, 32'hC, 32'h0);
      check("rw_pre_read_data", read_data, 32'h0000_005A);
      release_req();
      access(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5);
      check("rw_stall_cycles", 32'(stall_cnt), 32'd3);
      check("rw_rd_valid", 32'(rd_valid), 32'd0);
      check("rw_out1", out1, 32'hA5A5A5A5);
      check("rw_read_data", read_data, 32'h0000_005A);
      release_req();

      // LATENCY=1 instance: one stall cycle per request, DONE next cycle
      tick();
      wr1 = 1'b1; adr1 = 32'h0; wd1 = 32'hCAFEF00D;
      sample();
      check("l1_st_stall", 32'(stall1), 32'd1);
      tick();
      sample();
      check("l1_st_done_stall", 32'(stall1), 32'd0);
      check("l1_st_out1", out1_1, 32'hCAFEF00D);
      check("l1_st_rd_valid", 32'(rd_valid1), 32'd0);
      tick();
      wr1 = 1'b0; rd1 = 1'b1;
      sample();
      check("l1_ld_stall", 32'(stall1), 32'd1);
      tick();
      sample();
      check("l1_ld_done_stall", 32'(stall1), 32'd0);
      check("l1_ld_rd_valid", 32'(rd_valid1), 32'd1);
      check("l1_ld_read_data", read_data1, 32'hCAFEF00D);
      check("l1_ld_err", 32'(err1), 32'd0);
      tick();
      rd1 = 1'b0;
      sample();
      check("l1_idle_stall", 32'(stall1), 32'd0);
      check("l1_pulse_end", 32'(rd_valid1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
